// File: rtl/rv_pkg.sv
// Shared RV32I datapath definitions: data width, writeback result-select
// encodings and the width helpers used to size select buses.
package rv_pkg;

  localparam int RV_XLEN = 32;

  // Writeback result-select encodings (index into the result mux).
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  localparam logic [1:0] RES_IMM = 2'd3;

  // Ceiling log2; clog2(1) = 0. Bounded loop so it elaborates as a constant.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Select width for an n-way mux, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-way, WIDTH-bit selector. Selects beyond the last input
// return zero and raise err rather than aliasing onto a real input.
module mux_n
  import rv_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        y,
  output logic                    err
);

  // Pick input[sel], or flag an out-of-range select with a zero result.
  always_comb begin
    y   = '0;
    err = 1'b0;
    if (int'(sel) < NUM_IN) begin
      y   = in_data[int'(sel)*WIDTH +: WIDTH];
      err = 1'b0;
    end else begin
      y   = '0;
      err = 1'b1;
    end
  end

endmodule

// File: rtl/sel_mux_stage_chk.sv
// Simulation checker for sel_mux_stage handshake invariants.
module sel_mux_stage_chk #(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             reset,
  input logic             flush,
  input logic             in_valid,
  input logic             in_ready,
  input logic             skid_valid,
  input logic             out_valid,
  input logic             out_ready,
  input logic [WIDTH-1:0] out_data,
  input logic             out_err
);

  // The skid register must never be overwritten by a new accept.
  a_no_accept_with_skid: assert property (@(posedge clk) disable iff (reset)
    !(in_valid && in_ready && skid_valid));

  // A stalled output entry stays put until taken (or flushed/reset).
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=>
      (out_valid && $stable(out_data) && $stable(out_err)));

endmodule

// File: rtl/sel_mux_stage.sv
// Select-and-register pipeline stage with valid/ready handshaking and a
// one-entry skid buffer. in_ready depends only on registered state and
// reset, so there is no combinational path from out_ready to in_ready.
module sel_mux_stage
  import rv_pkg::*;
#(
  parameter int WIDTH  = RV_XLEN,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err
);

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_main_free;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_err;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;

  mux_n #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .in_data (in_data),
    .sel     (in_sel),
    .y       (w_sel_data),
    .err     (w_sel_err)
  );

  assign in_ready    = !r_skid_valid && !reset;
  assign w_accept    = in_valid && in_ready;
  // Main register may take a new entry when empty or being drained this cycle.
  assign w_main_free = !r_out_valid || out_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  // Main/skid register update: reset > flush > normal FIFO movement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_err    <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_err   <= 1'b0;
    end else if (flush) begin
      // Data registers keep stale contents; only the valid bits matter.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        // Older skid entry always leaves first to keep FIFO order.
        r_out_valid <= 1'b1;
        r_out_data  <= r_skid_data;
        r_out_err   <= r_skid_err;
        if (w_accept) begin
          // Unreachable while in_ready excludes skid_valid; kept for safety.
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_sel_data;
          r_skid_err   <= w_sel_err;
        end else begin
          r_skid_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_err   <= w_sel_err;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else begin
      // Main held by back-pressure: a new entry parks in the skid register.
      if (w_accept) begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= w_sel_data;
        r_skid_err   <= w_sel_err;
      end else begin
        r_skid_valid <= r_skid_valid;
      end
    end
  end

endmodule

// File: tb/tb_sel_mux_stage.sv
// Directed self-checking bench for sel_mux_stage.
module tb_sel_mux_stage;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_err;

  // Second instance with a non-power-of-two input count.
  logic         in_valid3;
  logic         in_ready3;
  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         out_valid3;
  logic         out_ready3;
  logic [31:0]  out_data3;
  logic         out_err3;

  int n_checks;
  int n_errors;

  sel_mux_stage #(.WIDTH(32), .NUM_IN(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  sel_mux_stage #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .flush     (1'b0),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .out_err   (out_err3)
  );

  sel_mux_stage_chk #(.WIDTH(32)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .skid_valid (u_dut.r_skid_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so outputs are settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 2'd0;
    in_data    = {32'h44, 32'h33, 32'h22, 32'h11};
    out_ready  = 1'b1;
    in_valid3  = 1'b0;
    in_sel3    = 2'd0;
    in_data3   = {32'h3000, 32'h2000, 32'h1000};
    out_ready3 = 1'b1;

    // Reset held two cycles with in_valid high.
    tick();
    tick();
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", out_data, 32'h0);
    check_val("rst_out_err", 32'(out_err), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b0;
    #1;
    check_val("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Streaming, full throughput, one-cycle latency.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      tick();
      check_val("stream_valid", 32'(out_valid), 32'd1);
      check_val("stream_data", out_data, 32'h11 * 32'(i + 1));
      check_val("stream_err", 32'(out_err), 32'd0);
      check_val("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check_val("stream_drained", 32'(out_valid), 32'd0);

    // Stall: three cycles of back-pressure while presenting A0, A1, A2.
    in_data   = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    check_val("stall_first", out_data, 32'hA0);
    check_val("stall_ready1", 32'(in_ready), 32'd1);
    in_sel = 2'd1;
    tick();
    check_val("stall_hold1", out_data, 32'hA0);
    check_val("stall_ready_fall", 32'(in_ready), 32'd0);
    in_sel = 2'd2;
    tick();
    check_val("stall_hold2", out_data, 32'hA0);
    check_val("stall_valid", 32'(out_valid), 32'd1);
    check_val("stall_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    check_val("release_a1", out_data, 32'hA1);
    check_val("release_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("release_a2", out_data, 32'hA2);
    check_val("release_a2_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    check_val("release_empty", 32'(out_valid), 32'd0);

    // Flush with main and skid full and a third entry waiting.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    in_sel = 2'd2;
    flush  = 1'b1;
    tick();
    check_val("flush_valid", 32'(out_valid), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("flush_nothing", 32'(out_valid), 32'd0);
    end
    // Flush on an accept into an empty stage discards that entry too.
    in_valid = 1'b1;
    in_sel   = 2'd3;
    flush    = 1'b1;
    tick();
    check_val("flush_accept_drop", 32'(out_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    check_val("flush_accept_gone", 32'(out_valid), 32'd0);

    // Out-of-range select on the three-input instance.
    in_valid3 = 1'b1;
    in_sel3   = 2'd3;
    tick();
    check_val("oor_valid", 32'(out_valid3), 32'd1);
    check_val("oor_data", out_data3, 32'h0);
    check_val("oor_err", 32'(out_err3), 32'd1);
    in_sel3 = 2'd2;
    tick();
    check_val("inr_data2", out_data3, 32'h3000);
    check_val("inr_err2", 32'(out_err3), 32'd0);
    in_sel3 = 2'd0;
    tick();
    check_val("inr_data0", out_data3, 32'h1000);
    in_valid3 = 1'b0;
    tick();
    check_val("oor_drained", 32'(out_valid3), 32'd0);

    // Reset with both entries held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    check_val("midrst_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    check_val("midrst_valid", 32'(out_valid), 32'd0);
    check_val("midrst_data", out_data, 32'h0);
    check_val("midrst_in_ready", 32'(in_ready), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    tick();
    check_val("resume_valid", 32'(out_valid), 32'd1);
    check_val("resume_data", out_data, 32'hA3);
    in_valid = 1'b0;
    tick();
    check_val("resume_empty", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sel_mux_stage.md
# sel_mux_stage

Parametrised N-way, WIDTH-bit select-and-register stage with valid/ready handshaking and a one-entry skid buffer. Generalises the fixed 4:1 32-bit mux into a pipeline-friendly block for the RV32I datapath, e.g. the writeback result select (ALU / load data / PC+4 / immediate). The block can stall, flush and sustain full throughput. Out-of-range selects are flagged instead of silently aliasing.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 4, number of selectable inputs (2..16, need not be a power of 2)
- SEL_W, clog2(NUM_IN) (minimum 1), select width; derived, not overridden

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all held and incoming entries
- in_valid  in  1  producer has a selection to present
- in_ready  out  1  stage can accept this cycle
- in_data  in  NUM_IN*WIDTH  packed inputs; input k is bits [k*WIDTH +: WIDTH]
- in_sel  in  SEL_W  index of the input to forward
- out_valid  out  1  out_data/out_err hold a valid entry
- out_ready  in  1  consumer takes the entry this cycle
- out_data  out  WIDTH  selected, registered data
- out_err  out  1  registered flag: in_sel was >= NUM_IN

## Operation
- Selection is combinational on the input side. The value sel_data is input[in_sel], or 0 with sel_err=1 when in_sel >= NUM_IN. Only WIDTH+1 bits are stored per entry.
- Storage consists of a main register (out_valid, out_data, out_err) and a skid register (skid_valid, skid_data, skid_err).
- in_ready = !skid_valid && !reset. It is purely a function of registers and reset, with no combinational path from out_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Per-clock update, with priority reset > flush > normal:
  - reset: all valid bits cleared; out_data=0, out_err=0, skid_data=0, skid_err=0.
  - flush: out_valid=0 and skid_valid=0. An accept on the same cycle is discarded. Data registers may keep stale values.
  - Main register empty, or draining: it loads the skid entry if skid_valid, otherwise the accepted entry if Accept, otherwise it goes empty.
  - When the main register loads from skid and Accept is also true, the accepted entry goes into skid. This case cannot occur, because in_ready=0 whenever skid_valid=1; assert this in simulation.
  - Main register full and not draining: it holds. An Accept writes the skid register and sets skid_valid.
- Ordering is strict FIFO. A skid entry always leaves before any later entry.
- in_data and in_sel are don't-care when in_valid=0.

## Timing
- Latency: an entry accepted at edge N is visible on out_* after edge N (one cycle), provided the main register was empty or draining.
- Throughput: one entry per cycle while out_ready=1.
- Back-pressure: the first cycle out_ready=0 with the main register full, the accepted entry goes to skid. in_ready falls after that edge, so at most 2 entries are held.
- Release: the first cycle out_ready=1 drains main and promotes skid. in_ready rises after that edge.
- out_valid/out_data/out_err stay stable while out_valid=1 and out_ready=0.
- Reset mid-operation: all held entries are lost. Outputs read 0/invalid after the reset edge. in_ready is 0 during reset and 1 on the first cycle after reset deasserts.
- Flush with reset both high: reset wins. The result is identical except the data registers are zeroed.

## Structure
- The shared package rv_pkg holds:
  - the clog2 constant function
  - the result-select encodings RES_ALU=0, RES_MEM=1, RES_PC4=2, RES_IMM=3
  - RV_XLEN=32
- Sub-module mux_n (parameters WIDTH, NUM_IN; ports in_data, sel, y, err) is purely combinational and instantiated once. It generalises the existing 4:1 mux.
- The handshake/skid logic stays in sel_mux_stage. No other sub-modules.

## Test plan
- Reset: hold reset 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_err=0, in_ready=0. After release in_ready=1.
- Streaming: WIDTH=32, NUM_IN=4, inputs {0x11,0x22,0x33,0x44}, in_sel cycling 0..3 every cycle, out_ready=1 -> out_data sequence 0x11,0x22,0x33,0x44, each one cycle after accept, with no bubbles.
- Stall: out_ready=0 for 3 cycles during a stream of 0xA0,0xA1,0xA2 -> in_ready falls after 2 accepts and 0xA2 waits at the input. Output holds 0xA0. On release the outputs are 0xA0,0xA1,0xA2 in order with no loss.
- Flush: main and skid both full, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of the three entries ever appears.
- Out-of-range select: NUM_IN=3, in_sel=3 -> out_data=0, out_err=1. A following in_sel=2 gives input 2 with out_err=0.
- Reset mid-stall: both entries held, assert reset 1 cycle -> out_valid=0, out_data=0, and the stream resumes cleanly afterward.
